// File: rtl/fir_pkg.sv
// Fixed-point constants and round/saturate helpers shared by FIR output stages.
// Combinational helpers only; they work on a 64-bit signed intermediate, so no pipeline and no flow control.
package fir_pkg;
    localparam int FIR_ACC_W = 38;
    localparam int SAMPLE_W  = 16;
    localparam int COEF_FRAC = 15;
    localparam int CALC_W    = 64;

    typedef logic signed [CALC_W-1:0] calc_t;

    typedef struct packed {
        calc_t sample;
        logic  sat;
    } sat_res_t;

    // Round half toward +inf, then arithmetic shift; 64 bits leave headroom so the bias add cannot wrap.
    function automatic calc_t round_shift(input calc_t value, input int shift);
        calc_t bias;
        bias = 64'sd1 <<< (shift - 1);
        return (value + bias) >>> shift;
    endfunction

    function automatic sat_res_t sat_clamp(input calc_t value, input int out_w);
        calc_t    max_v;
        calc_t    min_v;
        sat_res_t res;
        max_v   = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        min_v   = -(64'sd1 <<< (out_w - 1));
        res.sat = 1'b1;
        if (value > max_v) begin
            res.sample = max_v;
        end else if (value < min_v) begin
            res.sample = min_v;
        end else begin
            res.sample = value;
            res.sat    = 1'b0;
        end
        return res;
    endfunction

    function automatic sat_res_t sat_round(input calc_t value, input int shift);
        return sat_clamp(round_shift(value, shift), SAMPLE_W);
    endfunction
endpackage

// File: rtl/sync_fifo.sv
// Pointer-plus-count synchronous FIFO; registered write, head shown combinationally.
// A write while full is accepted only when a read happens in the same cycle; otherwise wr_en is ignored.
module sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_wr;
    logic             w_rd;

    assign full    = (r_count == CNT_W'(DEPTH));
    assign empty   = (r_count == '0);
    assign w_rd    = rd_en & ~empty;
    assign w_wr    = wr_en & (~full | w_rd);
    assign rd_data = r_mem[r_rd_ptr];

    // Storage is cleared on reset so the head reads zero out of reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) begin
                r_mem[r_wr_ptr] <= wr_data;
                r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

// File: rtl/fir_out_quantizer.sv
// Rounds, scales and saturates FIR accumulator results into a small output FIFO; 2-cycle latency into an empty FIFO.
// The FIR cannot be stalled: samples arriving at a full FIFO with no pop are dropped and counted, overrun is sticky.
module fir_out_quantizer
    import fir_pkg::*;
#(
    parameter int WIDTH_IN   = FIR_ACC_W,
    parameter int WIDTH_OUT  = SAMPLE_W,
    parameter int SHIFT      = COEF_FRAC,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH_IN-1:0]  fir_data,
    input  logic                 fir_valid,
    output logic [WIDTH_OUT-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 overrun,
    output logic [CNT_W-1:0]     sat_count,
    output logic [CNT_W-1:0]     drop_count
);
    localparam int RND_W = WIDTH_IN + 1 - SHIFT;

    calc_t                w_fir_ext;
    calc_t                w_round;
    calc_t                w_s1_ext;
    sat_res_t             w_clamp;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_pop;
    logic                 w_drop;

    logic                 r_s1_vld;
    logic [RND_W-1:0]     r_s1_dat;
    logic                 r_s2_vld;
    logic [WIDTH_OUT-1:0] r_s2_dat;
    logic                 r_s2_sat;
    logic                 r_overrun;
    logic [CNT_W-1:0]     r_sat_count;
    logic [CNT_W-1:0]     r_drop_count;

    assign w_fir_ext = {{(CALC_W-WIDTH_IN){fir_data[WIDTH_IN-1]}}, fir_data};
    assign w_round   = round_shift(w_fir_ext, SHIFT);
    assign w_s1_ext  = {{(CALC_W-RND_W){r_s1_dat[RND_W-1]}}, r_s1_dat};
    assign w_clamp   = sat_clamp(w_s1_ext, WIDTH_OUT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s1_vld <= 1'b0;
            r_s1_dat <= '0;
            r_s2_vld <= 1'b0;
            r_s2_dat <= '0;
            r_s2_sat <= 1'b0;
        end else begin
            r_s1_vld <= fir_valid;
            if (fir_valid) begin
                r_s1_dat <= w_round[RND_W-1:0];
            end
            r_s2_vld <= r_s1_vld;
            if (r_s1_vld) begin
                r_s2_dat <= w_clamp.sample[WIDTH_OUT-1:0];
                r_s2_sat <= w_clamp.sat;
            end
        end
    end

    assign out_valid = ~w_empty;
    assign w_pop     = out_valid & out_ready;
    // A pop in the same cycle frees the slot, so only a full FIFO without a pop loses the sample.
    assign w_drop    = r_s2_vld & w_full & ~w_pop;

    sync_fifo #(
        .WIDTH (WIDTH_OUT),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (r_s2_vld),
        .wr_data (r_s2_dat),
        .rd_en   (w_pop),
        .rd_data (out_data),
        .full    (w_full),
        .empty   (w_empty)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sat_count  <= '0;
            r_drop_count <= '0;
            r_overrun    <= 1'b0;
        end else begin
            if (r_s2_vld && r_s2_sat && (r_sat_count != '1)) begin
                r_sat_count <= r_sat_count + CNT_W'(1);
            end
            if (w_drop) begin
                r_overrun <= 1'b1;
                if (r_drop_count != '1) begin
                    r_drop_count <= r_drop_count + CNT_W'(1);
                end
            end
        end
    end

    assign overrun    = r_overrun;
    assign sat_count  = r_sat_count;
    assign drop_count = r_drop_count;
endmodule

// File: tb/tb_fir_out_quantizer.sv
// Bench for fir_out_quantizer: fixed vector table, hand-written FIFO/overrun/reset sequences and a randomized run
// checked against a queue-based model that quantizes with plain integer arithmetic.
module tb_fir_out_quantizer;
    localparam int WIDTH_IN  = 38;
    localparam int WIDTH_OUT = 16;
    localparam int SHIFT     = 15;
    localparam int DEPTH     = 4;
    localparam int CNT_W     = 16;
    localparam longint CMAX  = (longint'(1) << CNT_W) - 1;

    logic                 clk;
    logic                 rst;
    logic [WIDTH_IN-1:0]  fir_data;
    logic                 fir_valid;
    logic [WIDTH_OUT-1:0] out_data;
    logic                 out_valid;
    logic                 out_ready;
    logic                 overrun;
    logic [CNT_W-1:0]     sat_count;
    logic [CNT_W-1:0]     drop_count;

    int n_cmp;
    int n_bad;

    fir_out_quantizer #(
        .WIDTH_IN   (WIDTH_IN),
        .WIDTH_OUT  (WIDTH_OUT),
        .SHIFT      (SHIFT),
        .FIFO_DEPTH (DEPTH),
        .CNT_W      (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .fir_data   (fir_data),
        .fir_valid  (fir_valid),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .overrun    (overrun),
        .sat_count  (sat_count),
        .drop_count (drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: two-deep delay line of raw inputs feeding a bounded queue.
    longint mq[$];
    bit     p1_v, p2_v;
    longint p1_d, p2_d;
    longint m_sat, m_drop;
    bit     m_ovr;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic quant(input longint x, output longint q, output bit s);
        longint t, den, maxv, minv;
        den  = longint'(1) << SHIFT;
        maxv = (longint'(1) << (WIDTH_OUT - 1)) - 1;
        minv = -(maxv + 1);
        t = x + (den / 2);
        q = t / den;
        if ((t % den) != 0 && t < 0) q = q - 1;
        s = 1'b0;
        if (q > maxv) begin
            q = maxv;
            s = 1'b1;
        end else if (q < minv) begin
            q = minv;
            s = 1'b1;
        end
    endtask

    task automatic model_reset();
        mq.delete();
        p1_v = 0; p2_v = 0; p1_d = 0; p2_d = 0;
        m_sat = 0; m_drop = 0; m_ovr = 0;
    endtask

    task automatic model_edge(input bit in_v, input longint in_d, input bit rdy);
        longint q;
        bit     s;
        if (mq.size() > 0 && rdy) void'(mq.pop_front());
        if (p2_v) begin
            quant(p2_d, q, s);
            if (s && m_sat < CMAX) m_sat++;
            if (mq.size() < DEPTH) begin
                mq.push_back(q);
            end else begin
                if (m_drop < CMAX) m_drop++;
                m_ovr = 1;
            end
        end
        p2_v = p1_v; p2_d = p1_d;
        p1_v = in_v; p1_d = in_d;
    endtask

    task automatic tick();
        bit     in_v, rdy;
        longint in_d;
        in_v = fir_valid;
        in_d = longint'($signed(fir_data));
        rdy  = out_ready;
        @(posedge clk);
        if (!rst) model_reset();
        else model_edge(in_v, in_d, rdy);
        #1;
    endtask

    task automatic drive(input longint v);
        longint t;
        t = v;
        fir_data = t[WIDTH_IN-1:0];
    endtask

    task automatic check_model();
        chk("rnd_valid", longint'(out_valid), longint'(mq.size() > 0));
        if (mq.size() > 0) chk("rnd_data", longint'($signed(out_data)), mq[0]);
        chk("rnd_sat_count", longint'(sat_count), m_sat);
        chk("rnd_drop_count", longint'(drop_count), m_drop);
        chk("rnd_overrun", longint'(overrun), longint'(m_ovr));
    endtask

    task automatic rand_sample(output longint v);
        bit [63:0] raw;
        int        mode;
        raw  = {$urandom, $urandom};
        mode = $urandom_range(0, 3);
        case (mode)
            0: v = longint'($signed(raw[WIDTH_IN-1:0]));
            1: v = longint'($urandom_range(0, 32'h7fff_ffff)) - 64'sd1073741824;
            2: v = (longint'($urandom_range(0, 65535)) - 32768) * 32768 + 16384
                   + longint'($urandom_range(0, 2)) - 1;
            default: begin
                v = longint'($urandom_range(0, 131072)) - 65536;
                if (raw[0]) v = v + 64'sd1073741824;
                else v = v - 64'sd1073741824;
            end
        endcase
    endtask

    typedef struct {
        longint din;
        longint dout;
        bit     sat;
    } vec_t;

    vec_t vecs[14];

    initial begin
        longint exp_sat_total;
        longint v;
        n_cmp = 0;
        n_bad = 0;
        rst = 1'b0;
        fir_valid = 1'b0;
        fir_data = '0;
        out_ready = 1'b0;
        model_reset();

        vecs[0]  = '{16384, 1, 0};
        vecs[1]  = '{-16384, 0, 0};
        vecs[2]  = '{49151, 1, 0};
        vecs[3]  = '{-49152, -1, 0};
        vecs[4]  = '{64'sd2147483648, 32767, 1};
        vecs[5]  = '{-64'sd2147483648, -32768, 1};
        vecs[6]  = '{64'sd137438953471, 32767, 1};
        vecs[7]  = '{1073709056, 32767, 0};
        vecs[8]  = '{1073725440, 32767, 1};
        vecs[9]  = '{-1073758208, -32768, 0};
        vecs[10] = '{-1073758209, -32768, 1};
        vecs[11] = '{-64'sd137438953472, -32768, 1};
        vecs[12] = '{0, 0, 0};
        vecs[13] = '{16383, 0, 0};

        // Reset state
        #12;
        chk("reset_out_valid", longint'(out_valid), 0);
        chk("reset_out_data", longint'(out_data), 0);
        chk("reset_overrun", longint'(overrun), 0);
        chk("reset_sat_count", longint'(sat_count), 0);
        chk("reset_drop_count", longint'(drop_count), 0);
        rst = 1'b1;
        tick();
        tick();

        // Basic scaling and latency
        out_ready = 1'b1;
        drive(100 <<< 15);
        fir_valid = 1'b1;
        tick();
        fir_valid = 1'b0;
        chk("lat_valid_n", longint'(out_valid), 0);
        tick();
        chk("lat_valid_n1", longint'(out_valid), 0);
        tick();
        chk("lat_valid_n2", longint'(out_valid), 1);
        chk("lat_data", longint'($signed(out_data)), 100);
        chk("lat_sat_count", longint'(sat_count), 0);
        tick();
        chk("lat_popped", longint'(out_valid), 0);

        // Rounding and saturation table
        exp_sat_total = 0;
        for (int i = 0; i < 14; i++) begin
            drive(vecs[i].din);
            fir_valid = 1'b1;
            tick();
            fir_valid = 1'b0;
            tick();
            tick();
            exp_sat_total += longint'(vecs[i].sat);
            chk($sformatf("vec%0d_valid", i), longint'(out_valid), 1);
            chk($sformatf("vec%0d_data", i), longint'($signed(out_data)), vecs[i].dout);
            chk($sformatf("vec%0d_sat_count", i), longint'(sat_count), exp_sat_total);
            tick();
        end

        // Overrun: five samples into a stalled four-entry FIFO
        out_ready = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            drive(longint'(k) <<< 15);
            fir_valid = 1'b1;
            tick();
        end
        fir_valid = 1'b0;
        repeat (3) tick();
        chk("ovr_drop_count", longint'(drop_count), 1);
        chk("ovr_overrun", longint'(overrun), 1);
        chk("ovr_sat_count", longint'(sat_count), exp_sat_total);
        out_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            chk($sformatf("ovr_valid%0d", k), longint'(out_valid), 1);
            chk($sformatf("ovr_data%0d", k), longint'($signed(out_data)), k);
            tick();
        end
        chk("ovr_drained", longint'(out_valid), 0);
        out_ready = 1'b0;

        // Full FIFO with a pop in the same cycle the new sample is written
        for (int k = 11; k <= 14; k++) begin
            drive(longint'(k) <<< 15);
            fir_valid = 1'b1;
            tick();
        end
        fir_valid = 1'b0;
        repeat (3) tick();
        drive(9 <<< 15);
        fir_valid = 1'b1;
        tick();
        fir_valid = 1'b0;
        tick();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("fullpop_drop_count", longint'(drop_count), 1);
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            v = (k == 3) ? 9 : 12 + k;
            chk($sformatf("fullpop_data%0d", k), longint'($signed(out_data)), v);
            tick();
        end
        chk("fullpop_drained", longint'(out_valid), 0);

        // Randomized run against the model
        for (int c = 0; c < 3000; c++) begin
            rand_sample(v);
            drive(v);
            fir_valid = ($urandom_range(0, 9) < 6);
            out_ready = ($urandom_range(0, 9) < 5);
            tick();
            check_model();
        end

        // Reset mid-stream with three entries queued and two more in flight
        fir_valid = 1'b0;
        out_ready = 1'b1;
        repeat (6) tick();
        out_ready = 1'b0;
        for (int k = 21; k <= 25; k++) begin
            drive(longint'(k) <<< 15);
            fir_valid = 1'b1;
            tick();
        end
        check_model();
        #2;
        rst = 1'b0;
        fir_valid = 1'b0;
        #1;
        chk("midrst_out_valid", longint'(out_valid), 0);
        chk("midrst_out_data", longint'(out_data), 0);
        chk("midrst_sat_count", longint'(sat_count), 0);
        chk("midrst_drop_count", longint'(drop_count), 0);
        chk("midrst_overrun", longint'(overrun), 0);
        tick();
        rst = 1'b1;
        tick();
        out_ready = 1'b1;
        drive(7 <<< 15);
        fir_valid = 1'b1;
        tick();
        fir_valid = 1'b0;
        chk("post_rst_valid_n", longint'(out_valid), 0);
        tick();
        chk("post_rst_valid_n1", longint'(out_valid), 0);
        tick();
        chk("post_rst_valid_n2", longint'(out_valid), 1);
        chk("post_rst_data", longint'($signed(out_data)), 7);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
